// File: rtl/vh_pkg.sv
// Shared types and helpers for the valid/hold stream source and sink blocks.
package vh_pkg;

  typedef enum logic {VH_INCR = 1'b0, VH_LFSR = 1'b1} vh_mode_e;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} vh_src_state_e;

  localparam logic [15:0] VH_LFSR16_POLY = 16'hB400;

  // Next word of a sequence, computed on a 64-bit container and masked to w bits
  // so one helper serves any data width up to 64.
  function automatic logic [63:0] vh_next(vh_mode_e mode, logic [63:0] d,
                                          logic [63:0] poly, int unsigned w);
    logic [63:0] mask;
    logic [63:0] dm;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    dm   = d & mask;
    if (mode == VH_LFSR) return (dm >> 1) ^ (dm[0] ? (poly & mask) : 64'd0);
    else                 return (dm + 64'd1) & mask;
  endfunction

endpackage

// File: rtl/vh_seq_gen.sv
// Sequence generator: holds the current word and steps it in increment or LFSR mode.
module vh_seq_gen
  import vh_pkg::*;
#(
  parameter int              WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY = WIDTH'(VH_LFSR16_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  vh_mode_e         mode,
  input  logic [WIDTH-1:0] seed,
  input  logic             adv,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_q;
  vh_mode_e         mode_q;

  // Load latches mode and seed (zero LFSR seed forced to 1 to avoid lock-up); adv steps.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      mode_q <= VH_INCR;
    end else if (load) begin
      mode_q <= mode;
      data_q <= (mode == VH_LFSR && seed == '0) ? WIDTH'(1) : seed;
    end else if (adv) begin
      data_q <= WIDTH'(vh_next(mode_q, 64'(data_q), 64'(POLY), WIDTH));
    end
  end

  assign data = data_q;

endmodule

// File: rtl/vh_seq_source.sv
// Valid/hold stream source: emits a programmable run of incrementing or LFSR words
// with optional inter-word gaps, honouring sink hold backpressure.
module vh_seq_source
  import vh_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               CNT_W     = 16,
  parameter int               GAP_W     = 8,
  parameter logic [WIDTH-1:0] LFSR_POLY = WIDTH'(VH_LFSR16_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  input  logic             hold_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_o
);

  vh_src_state_e    state_q, state_n;
  logic [CNT_W-1:0] cnt_q, sent_q, sent_inc;
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic             valid_q, busy_q, done_q;
  logic             load, xfer;

  assign xfer     = (state_q == SEND) && !hold_i;
  assign sent_inc = sent_q + CNT_W'(1);

  vh_seq_gen #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_gen (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .mode (vh_mode_e'(mode_i)),
    .seed (seed_i),
    .adv  (xfer),
    .data (data_o)
  );

  // Next-state decode; start is only looked at in IDLE so later pulses are dropped.
  always_comb begin
    state_n = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: if (start_i) begin
        if (count_i != '0) begin
          state_n = SEND;
          load    = 1'b1;
        end else begin
          state_n = DONE;
        end
      end
      SEND: if (xfer) begin
        if (sent_inc == cnt_q)   state_n = DONE;
        else if (gap_q != '0)    state_n = GAP;
        else                     state_n = SEND;
      end
      GAP:  if (gap_cnt == GAP_W'(1)) state_n = SEND;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State, run parameters, counters and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      sent_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      valid_q <= (state_n == SEND);
      busy_q  <= (state_n == SEND) || (state_n == GAP);
      done_q  <= (state_n == DONE);
      if (state_q == IDLE && start_i) begin
        cnt_q  <= count_i;
        gap_q  <= gap_i;
        sent_q <= '0;
      end else if (xfer) begin
        sent_q <= sent_inc;
      end
      if (xfer && state_n == GAP)  gap_cnt <= gap_q;
      else if (state_q == GAP)     gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign sent_o  = sent_q;

endmodule
